// File: rtl/mmu_asid.sv
// ASID-tagged, fully associative TLB MMU with a kernel direct-mapped segment and sub-word stores.
// Define MMU_TLB_PROBE_EN to add the registered TLB probe port.
module mmu_asid #(
    parameter int unsigned TLB_INDEX_WIDTH = 4,
    parameter int unsigned ASID_WIDTH      = 8,
    parameter int unsigned ENTRY_WIDTH     = 64 + ASID_WIDTH,
    parameter int unsigned MEM_OPT_WIDTH   = 4,
    parameter int unsigned EXC_CODE_WIDTH  = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tlb_we_i,
    input  logic [TLB_INDEX_WIDTH-1:0] tlb_windex_i,
    input  logic [ENTRY_WIDTH-1:0]     tlb_wentry_i,
    input  logic [ASID_WIDTH-1:0]      cur_asid_i,
    input  logic                       kernel_mode_i,
    input  logic [31:0]                instr_addr_i,
    output logic [31:0]                instr_out_o,
    input  logic [MEM_OPT_WIDTH-1:0]   data_opt_i,
    input  logic [31:0]                data_addr_i,
    input  logic [31:0]                data_in_i,
    output logic [31:0]                data_out_o,
    output logic                       busy_o,
    output logic [EXC_CODE_WIDTH-1:0]  exc_code_o,
    output logic [31:0]                dev_mem_addr_o,
    input  logic [31:0]                dev_mem_data_in_i,
    output logic [31:0]                dev_mem_data_out_o,
    output logic                       dev_mem_is_write_o,
    input  logic                       dev_mem_busy_i
`ifdef MMU_TLB_PROBE_EN
    ,
    input  logic                       probe_req_i,
    input  logic [18:0]                probe_vpn2_i,
    output logic                       probe_hit_o,
    output logic [TLB_INDEX_WIDTH-1:0] probe_index_o
`endif
);

    localparam int unsigned NumEntries = 1 << TLB_INDEX_WIDTH;

    localparam logic [MEM_OPT_WIDTH-1:0] OptNone = MEM_OPT_WIDTH'(0);
    localparam logic [MEM_OPT_WIDTH-1:0] OptLw   = MEM_OPT_WIDTH'(1);
    localparam logic [MEM_OPT_WIDTH-1:0] OptLbs  = MEM_OPT_WIDTH'(2);
    localparam logic [MEM_OPT_WIDTH-1:0] OptLbu  = MEM_OPT_WIDTH'(3);
    localparam logic [MEM_OPT_WIDTH-1:0] OptLhs  = MEM_OPT_WIDTH'(4);
    localparam logic [MEM_OPT_WIDTH-1:0] OptLhu  = MEM_OPT_WIDTH'(5);
    localparam logic [MEM_OPT_WIDTH-1:0] OptSw   = MEM_OPT_WIDTH'(6);
    localparam logic [MEM_OPT_WIDTH-1:0] OptSb   = MEM_OPT_WIDTH'(7);
    localparam logic [MEM_OPT_WIDTH-1:0] OptSh   = MEM_OPT_WIDTH'(8);

    localparam logic [EXC_CODE_WIDTH-1:0] ExcNone   = EXC_CODE_WIDTH'(0);
    localparam logic [EXC_CODE_WIDTH-1:0] ExcAdel   = EXC_CODE_WIDTH'(1);
    localparam logic [EXC_CODE_WIDTH-1:0] ExcAdes   = EXC_CODE_WIDTH'(2);
    localparam logic [EXC_CODE_WIDTH-1:0] ExcTlbl   = EXC_CODE_WIDTH'(3);
    localparam logic [EXC_CODE_WIDTH-1:0] ExcTlbs   = EXC_CODE_WIDTH'(4);
    localparam logic [EXC_CODE_WIDTH-1:0] ExcTlbMod = EXC_CODE_WIDTH'(5);

    // Entry layout: {VPN2, ASID, G, PFN1, D1, V1, PFN0, D0, V0}
    localparam int unsigned V0Bit   = 0;
    localparam int unsigned D0Bit   = 1;
    localparam int unsigned Pfn0Lsb = 2;
    localparam int unsigned V1Bit   = 22;
    localparam int unsigned D1Bit   = 23;
    localparam int unsigned Pfn1Lsb = 24;
    localparam int unsigned GBit    = 44;
    localparam int unsigned AsidLsb = 45;
    localparam int unsigned VpnLsb  = 45 + ASID_WIDTH;

    typedef enum logic [1:0] {StIdle, StMerge, StWrite} state_e;

    state_e                     state_q, state_d;
    logic [ENTRY_WIDTH-1:0]     tlb_q [NumEntries];
    logic [31:0]                data_out_q, data_out_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [31:0]                paddr_q, paddr_d;
    logic [MEM_OPT_WIDTH-1:0]   opt_q, opt_d;
    logic [1:0]                 off_q, off_d;

    logic [31:0]                vaddr, phys_word, load_val, merged;
    logic [TLB_INDEX_WIDTH-1:0] hit_idx;
    logic [19:0]                pfn;
    logic [7:0]                 rd_byte;
    logic [15:0]                rd_half;
    logic hit, pg_v, pg_d, page_ok, page_wr, direct;
    logic is_store, is_half, is_word, misalign, accept;
    logic [EXC_CODE_WIDTH-1:0]  exc;

    function automatic logic entry_match(input logic [ENTRY_WIDTH-1:0] e,
                                         input logic [18:0] vpn2,
                                         input logic [ASID_WIDTH-1:0] asid);
        return (e[VpnLsb +: 19] == vpn2) && (e[GBit] || (e[AsidLsb +: ASID_WIDTH] == asid));
    endfunction

    always_comb begin
        vaddr = ((state_q != StIdle) || (data_opt_i != OptNone)) ? data_addr_i : instr_addr_i;
        hit     = 1'b0;
        hit_idx = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (entry_match(tlb_q[i], vaddr[31:13], cur_asid_i)) begin
                hit     = 1'b1;
                hit_idx = i[TLB_INDEX_WIDTH-1:0];
            end
        end
        if (vaddr[12]) begin
            pfn  = tlb_q[hit_idx][Pfn1Lsb +: 20];
            pg_v = tlb_q[hit_idx][V1Bit];
            pg_d = tlb_q[hit_idx][D1Bit];
        end else begin
            pfn  = tlb_q[hit_idx][Pfn0Lsb +: 20];
            pg_v = tlb_q[hit_idx][V0Bit];
            pg_d = tlb_q[hit_idx][D0Bit];
        end
        direct = kernel_mode_i && (vaddr[31:30] == 2'b10);
        if (direct) begin
            phys_word = {3'b000, vaddr[28:2], 2'b00};
            page_ok   = 1'b1;
            page_wr   = 1'b1;
        end else begin
            phys_word = {pfn, vaddr[11:2], 2'b00};
            page_ok   = hit && pg_v;
            page_wr   = pg_d;
        end
    end

    always_comb begin
        is_store = (data_opt_i == OptSw) || (data_opt_i == OptSb) || (data_opt_i == OptSh);
        is_half  = (data_opt_i == OptLhs) || (data_opt_i == OptLhu) || (data_opt_i == OptSh);
        is_word  = (data_opt_i == OptLw) || (data_opt_i == OptSw) || (data_opt_i == OptNone);
        misalign = is_word ? (vaddr[1:0] != 2'b00) : (is_half && vaddr[0]);
        exc = ExcNone;
        if (state_q == StIdle) begin
            if (misalign || (!kernel_mode_i && vaddr[31])) begin
                exc = is_store ? ExcAdes : ExcAdel;
            end else if (!page_ok) begin
                exc = is_store ? ExcTlbs : ExcTlbl;
            end else if (is_store && !page_wr) begin
                exc = ExcTlbMod;
            end
        end
        accept = (state_q == StIdle) && !dev_mem_busy_i && (data_opt_i != OptNone) &&
                 (exc == ExcNone);
    end

    always_comb begin
        rd_byte = dev_mem_data_in_i[{vaddr[1:0], 3'b000} +: 8];
        rd_half = vaddr[1] ? dev_mem_data_in_i[31:16] : dev_mem_data_in_i[15:0];
        case (data_opt_i)
            OptLbs:  load_val = {{24{rd_byte[7]}}, rd_byte};
            OptLbu:  load_val = {24'h0, rd_byte};
            OptLhs:  load_val = {{16{rd_half[15]}}, rd_half};
            OptLhu:  load_val = {16'h0, rd_half};
            default: load_val = dev_mem_data_in_i;
        endcase
        merged = dev_mem_data_in_i;
        if (opt_q == OptSb) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        wdata_d    = wdata_q;
        paddr_d    = paddr_q;
        opt_d      = opt_q;
        off_d      = off_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    paddr_d = phys_word;
                    opt_d   = data_opt_i;
                    off_d   = vaddr[1:0];
                    if (is_store) begin
                        wdata_d = data_in_i;
                        state_d = (data_opt_i == OptSw) ? StWrite : StMerge;
                    end else begin
                        data_out_d = load_val;
                    end
                end
            end
            StMerge: begin
                wdata_d = merged;
                state_d = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            data_out_q <= '0;
            wdata_q    <= '0;
            paddr_q    <= '0;
            opt_q      <= OptNone;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            wdata_q    <= wdata_d;
            paddr_q    <= paddr_d;
            opt_q      <= opt_d;
            off_q      <= off_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumEntries; i++) begin
                tlb_q[i] <= '0;
            end
        end else if (tlb_we_i) begin
            tlb_q[tlb_windex_i] <= tlb_wentry_i;
        end
    end

    assign instr_out_o        = dev_mem_data_in_i;
    assign data_out_o         = data_out_q;
    assign dev_mem_data_out_o = wdata_q;
    assign dev_mem_is_write_o = (state_q == StWrite);
    assign dev_mem_addr_o     = (state_q == StIdle) ? phys_word : paddr_q;
    assign exc_code_o         = exc;
    assign busy_o = ((state_q != StIdle) || is_store || dev_mem_busy_i) && (exc == ExcNone);

`ifdef MMU_TLB_PROBE_EN
    logic                       probe_hit_q, probe_hit_d;
    logic [TLB_INDEX_WIDTH-1:0] probe_index_q, probe_index_d;

    always_comb begin
        probe_hit_d   = 1'b0;
        probe_index_d = '0;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (entry_match(tlb_q[i], probe_vpn2_i, cur_asid_i)) begin
                probe_hit_d   = 1'b1;
                probe_index_d = i[TLB_INDEX_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            probe_hit_q   <= 1'b0;
            probe_index_q <= '0;
        end else if (probe_req_i) begin
            probe_hit_q   <= probe_hit_d;
            probe_index_q <= probe_index_d;
        end
    end

    assign probe_hit_o   = probe_hit_q;
    assign probe_index_o = probe_index_q;
`endif

endmodule

// File: tb/tb_mmu_asid.sv
// Directed self-checking bench for mmu_asid; probe checks compile in with MMU_TLB_PROBE_EN.
module tb_mmu_asid;

    localparam logic [3:0] OPT_NONE = 4'd0, LW = 4'd1, LBS = 4'd2, LBU = 4'd3, LHS = 4'd4;
    localparam logic [3:0] LHU = 4'd5, SW = 4'd6, SB = 4'd7, SH = 4'd8;
    localparam logic [2:0] EC_NONE = 3'd0, ADEL = 3'd1, ADES = 3'd2, TLBL = 3'd3;
    localparam logic [2:0] TLBS = 3'd4, TLBMOD = 3'd5;

    logic        clk, rst_n;
    logic        tlb_we;
    logic [3:0]  tlb_windex;
    logic [71:0] tlb_wentry;
    logic [7:0]  cur_asid;
    logic        kernel_mode;
    logic [31:0] instr_addr, instr_out;
    logic [3:0]  data_opt;
    logic [31:0] data_addr, data_in, data_out;
    logic        busy;
    logic [2:0]  exc_code;
    logic [31:0] dev_mem_addr, dev_mem_data_in, dev_mem_data_out;
    logic        dev_mem_is_write, dev_mem_busy;
`ifdef MMU_TLB_PROBE_EN
    logic        probe_req, probe_hit;
    logic [18:0] probe_vpn2;
    logic [3:0]  probe_index;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mmu_asid dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .tlb_we_i           (tlb_we),
        .tlb_windex_i       (tlb_windex),
        .tlb_wentry_i       (tlb_wentry),
        .cur_asid_i         (cur_asid),
        .kernel_mode_i      (kernel_mode),
        .instr_addr_i       (instr_addr),
        .instr_out_o        (instr_out),
        .data_opt_i         (data_opt),
        .data_addr_i        (data_addr),
        .data_in_i          (data_in),
        .data_out_o         (data_out),
        .busy_o             (busy),
        .exc_code_o         (exc_code),
        .dev_mem_addr_o     (dev_mem_addr),
        .dev_mem_data_in_i  (dev_mem_data_in),
        .dev_mem_data_out_o (dev_mem_data_out),
        .dev_mem_is_write_o (dev_mem_is_write),
        .dev_mem_busy_i     (dev_mem_busy)
`ifdef MMU_TLB_PROBE_EN
        ,
        .probe_req_i        (probe_req),
        .probe_vpn2_i       (probe_vpn2),
        .probe_hit_o        (probe_hit),
        .probe_index_o      (probe_index)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] mk_entry(input logic [18:0] vpn2, input logic [7:0] asid,
                                             input logic g, input logic [19:0] pfn1,
                                             input logic d1, input logic v1,
                                             input logic [19:0] pfn0, input logic d0,
                                             input logic v0);
        return {vpn2, asid, g, pfn1, d1, v1, pfn0, d0, v0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tlb_write(input logic [3:0] idx, input logic [71:0] e);
        tlb_we = 1'b1; tlb_windex = idx; tlb_wentry = e;
        tick();
        tlb_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tlb_we = 1'b0; tlb_windex = '0; tlb_wentry = '0; cur_asid = '0;
        kernel_mode = 1'b0; instr_addr = '0; data_opt = OPT_NONE; data_addr = '0;
        data_in = '0; dev_mem_data_in = '0; dev_mem_busy = 1'b0;
`ifdef MMU_TLB_PROBE_EN
        probe_req = 1'b0; probe_vpn2 = '0;
`endif
        #12;
        chk_cnt++; if (data_out !== 32'h0) $display("FAIL reset_data_out got=%h exp=0", data_out); else pass_cnt++;
        chk_cnt++; if (dev_mem_data_out !== 32'h0) $display("FAIL reset_wdata got=%h exp=0", dev_mem_data_out); else pass_cnt++;
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL reset_is_write got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        chk_cnt++; if (exc_code !== TLBL) $display("FAIL reset_tlb_invalid got=%0d exp=%0d", exc_code, TLBL); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        kernel_mode = 1'b1; instr_addr = 32'h8000_0100; data_addr = 32'h0000_0FF0;
        dev_mem_data_in = 32'h1234_5678; #1;
        chk_cnt++; if (exc_code !== EC_NONE) $display("FAIL fetch_kseg_exc got=%0d exp=0", exc_code); else pass_cnt++;
        chk_cnt++; if (dev_mem_addr !== 32'h0000_0100) $display("FAIL fetch_kseg_addr got=%h exp=00000100", dev_mem_addr); else pass_cnt++;
        chk_cnt++; if (instr_out !== 32'h1234_5678) $display("FAIL fetch_instr_out got=%h exp=12345678", instr_out); else pass_cnt++;
        dev_mem_busy = 1'b1; #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL fetch_mem_busy got=%b exp=1", busy); else pass_cnt++;
        instr_addr = 32'h8000_0102; #1;
        chk_cnt++; if (exc_code !== ADEL) $display("FAIL fetch_misalign got=%0d exp=%0d", exc_code, ADEL); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL fetch_exc_busy got=%b exp=0", busy); else pass_cnt++;
        dev_mem_busy = 1'b0; kernel_mode = 1'b0; instr_addr = 32'h8000_0100; #1;
        chk_cnt++; if (exc_code !== ADEL) $display("FAIL fetch_user_kseg got=%0d exp=%0d", exc_code, ADEL); else pass_cnt++;
    endtask

    task automatic test_tlb_load();
        tlb_write(4'd3, mk_entry(19'h10, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00123, 1'b1, 1'b1));
        cur_asid = 8'd5; kernel_mode = 1'b0; data_opt = LW; data_addr = 32'h0002_0004;
        dev_mem_data_in = 32'hCAFE_BABE; #1;
        chk_cnt++; if (dev_mem_addr !== 32'h0012_3004) $display("FAIL lw_paddr got=%h exp=00123004", dev_mem_addr); else pass_cnt++;
        chk_cnt++; if (exc_code !== EC_NONE) $display("FAIL lw_exc got=%0d exp=0", exc_code); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL lw_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        dev_mem_busy = 1'b1; dev_mem_data_in = 32'h0BAD_0BAD; #1;
        chk_cnt++; if (data_out !== 32'hCAFE_BABE) $display("FAIL lw_data got=%h exp=cafebabe", data_out); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL lw_stall_busy got=%b exp=1", busy); else pass_cnt++;
        tick();
        data_opt = OPT_NONE; dev_mem_busy = 1'b0; #1;
        chk_cnt++; if (data_out !== 32'hCAFE_BABE) $display("FAIL lw_stall_hold got=%h exp=cafebabe", data_out); else pass_cnt++;
    endtask

    task automatic test_asid_global();
        cur_asid = 8'd6; data_opt = LW; data_addr = 32'h0002_0004; dev_mem_data_in = 32'h5555_0000; #1;
        chk_cnt++; if (exc_code !== TLBL) $display("FAIL asid_miss got=%0d exp=%0d", exc_code, TLBL); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL asid_miss_busy got=%b exp=0", busy); else pass_cnt++;
        tlb_we = 1'b1; tlb_windex = 4'd3;
        tlb_wentry = mk_entry(19'h10, 8'd5, 1'b1, 20'h0, 1'b0, 1'b0, 20'h00123, 1'b1, 1'b1); #1;
        chk_cnt++; if (exc_code !== TLBL) $display("FAIL write_same_cycle got=%0d exp=%0d", exc_code, TLBL); else pass_cnt++;
        tick();
        tlb_we = 1'b0;
        chk_cnt++; if (data_out !== 32'hCAFE_BABE) $display("FAIL asid_miss_no_load got=%h exp=cafebabe", data_out); else pass_cnt++;
        #1;
        chk_cnt++; if (exc_code !== EC_NONE) $display("FAIL global_hit got=%0d exp=0", exc_code); else pass_cnt++;
        chk_cnt++; if (dev_mem_addr !== 32'h0012_3004) $display("FAIL global_paddr got=%h exp=00123004", dev_mem_addr); else pass_cnt++;
        tick();
        data_opt = OPT_NONE; cur_asid = 8'd5; #1;
        chk_cnt++; if (data_out !== 32'h5555_0000) $display("FAIL global_data got=%h exp=55550000", data_out); else pass_cnt++;
    endtask

    task automatic test_sub_stores();
        instr_addr = 32'h0002_0000; dev_mem_data_in = 32'h1122_3344;
        data_opt = SB; data_addr = 32'h0002_0006; data_in = 32'h0000_00AB; #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL sb_busy0 got=%b exp=1", busy); else pass_cnt++;
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL sb_write0 got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        tick();
        data_opt = OPT_NONE; #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL sb_busy1 got=%b exp=1", busy); else pass_cnt++;
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL sb_write1 got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        tick();
        chk_cnt++; if (dev_mem_is_write !== 1'b1) $display("FAIL sb_write2 got=%b exp=1", dev_mem_is_write); else pass_cnt++;
        chk_cnt++; if (dev_mem_data_out !== 32'h11AB_3344) $display("FAIL sb_merge got=%h exp=11ab3344", dev_mem_data_out); else pass_cnt++;
        chk_cnt++; if (dev_mem_addr !== 32'h0012_3004) $display("FAIL sb_addr got=%h exp=00123004", dev_mem_addr); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL sb_busy2 got=%b exp=1", busy); else pass_cnt++;
        tick();
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL sb_write3 got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL sb_busy3 got=%b exp=0", busy); else pass_cnt++;
        data_opt = SW; data_addr = 32'h0002_0008; data_in = 32'hDEAD_BEEF; #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL sw_busy0 got=%b exp=1", busy); else pass_cnt++;
        tick();
        data_opt = OPT_NONE; #1;
        chk_cnt++; if (dev_mem_is_write !== 1'b1) $display("FAIL sw_write1 got=%b exp=1", dev_mem_is_write); else pass_cnt++;
        chk_cnt++; if (dev_mem_data_out !== 32'hDEAD_BEEF) $display("FAIL sw_data got=%h exp=deadbeef", dev_mem_data_out); else pass_cnt++;
        chk_cnt++; if (dev_mem_addr !== 32'h0012_3008) $display("FAIL sw_addr got=%h exp=00123008", dev_mem_addr); else pass_cnt++;
        tick();
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL sw_write2 got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        data_opt = SH; data_addr = 32'h0002_0002; data_in = 32'h7777_BEEF; #1;
        tick();
        data_opt = OPT_NONE;
        tick();
        chk_cnt++; if (dev_mem_data_out !== 32'hBEEF_3344) $display("FAIL sh_merge got=%h exp=beef3344", dev_mem_data_out); else pass_cnt++;
        tick();
    endtask

    task automatic test_kernel_loads();
        kernel_mode = 1'b1; dev_mem_data_in = 32'h8001_0000;
        data_opt = LHS; data_addr = 32'h8000_0002; #1;
        chk_cnt++; if (exc_code !== EC_NONE) $display("FAIL lhs_k_exc got=%0d exp=0", exc_code); else pass_cnt++;
        chk_cnt++; if (dev_mem_addr !== 32'h0000_0000) $display("FAIL lhs_k_addr got=%h exp=00000000", dev_mem_addr); else pass_cnt++;
        tick();
        data_opt = LHU; #1;
        chk_cnt++; if (data_out !== 32'hFFFF_8001) $display("FAIL lhs_data got=%h exp=ffff8001", data_out); else pass_cnt++;
        tick();
        data_opt = LBS; data_addr = 32'h8000_0003; #1;
        chk_cnt++; if (data_out !== 32'h0000_8001) $display("FAIL lhu_data got=%h exp=00008001", data_out); else pass_cnt++;
        tick();
        data_opt = LBU; data_addr = 32'h8000_0002; #1;
        chk_cnt++; if (data_out !== 32'hFFFF_FF80) $display("FAIL lbs_data got=%h exp=ffffff80", data_out); else pass_cnt++;
        tick();
        kernel_mode = 1'b0; data_opt = LHS; #1;
        chk_cnt++; if (data_out !== 32'h0000_0001) $display("FAIL lbu_data got=%h exp=00000001", data_out); else pass_cnt++;
        chk_cnt++; if (exc_code !== ADEL) $display("FAIL lhs_user got=%0d exp=%0d", exc_code, ADEL); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL lhs_user_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        kernel_mode = 1'b1; data_addr = 32'h8000_0001; #1;
        chk_cnt++; if (exc_code !== ADEL) $display("FAIL lh_misalign got=%0d exp=%0d", exc_code, ADEL); else pass_cnt++;
        tick();
        data_opt = OPT_NONE; kernel_mode = 1'b0; #1;
        chk_cnt++; if (data_out !== 32'h0000_0001) $display("FAIL exc_no_load got=%h exp=00000001", data_out); else pass_cnt++;
    endtask

    task automatic test_store_faults();
        tlb_write(4'd4, mk_entry(19'h20, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h00456, 1'b0, 1'b1));
        data_opt = SW; data_addr = 32'h0004_0000; data_in = 32'h5555_5555; #1;
        chk_cnt++; if (exc_code !== TLBMOD) $display("FAIL sw_clean got=%0d exp=%0d", exc_code, TLBMOD); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL sw_clean_busy got=%b exp=0", busy); else pass_cnt++;
        tick();
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL sw_clean_write got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        chk_cnt++; if (dev_mem_data_out !== 32'hBEEF_3344) $display("FAIL sw_clean_latch got=%h exp=beef3344", dev_mem_data_out); else pass_cnt++;
        data_opt = LW; #1;
        chk_cnt++; if (dev_mem_addr !== 32'h0045_6000) $display("FAIL lw_clean_addr got=%h exp=00456000", dev_mem_addr); else pass_cnt++;
        data_addr = 32'h0004_1000; #1;
        chk_cnt++; if (exc_code !== TLBL) $display("FAIL odd_invalid got=%0d exp=%0d", exc_code, TLBL); else pass_cnt++;
        data_opt = SW; data_addr = 32'h0006_0000; #1;
        chk_cnt++; if (exc_code !== TLBS) $display("FAIL sw_miss got=%0d exp=%0d", exc_code, TLBS); else pass_cnt++;
        data_addr = 32'h0002_0002; #1;
        chk_cnt++; if (exc_code !== ADES) $display("FAIL sw_misalign got=%0d exp=%0d", exc_code, ADES); else pass_cnt++;
        data_opt = SH; data_addr = 32'h8000_0000; #1;
        chk_cnt++; if (exc_code !== ADES) $display("FAIL sh_user_kseg got=%0d exp=%0d", exc_code, ADES); else pass_cnt++;
        tick();
        data_opt = OPT_NONE;
    endtask

    task automatic test_reset_mid_merge();
        dev_mem_data_in = 32'h1122_3344; data_opt = SB; data_addr = 32'h0002_0006; data_in = 32'hCD; #1;
        tick();
        data_opt = OPT_NONE; #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL merge_busy got=%b exp=1", busy); else pass_cnt++;
        rst_n = 1'b0; #1;
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL rst_write got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        chk_cnt++; if (dev_mem_data_out !== 32'h0) $display("FAIL rst_wdata got=%h exp=0", dev_mem_data_out); else pass_cnt++;
        chk_cnt++; if (data_out !== 32'h0) $display("FAIL rst_data_out got=%h exp=0", data_out); else pass_cnt++;
        tick();
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL rst_hold_write got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        rst_n = 1'b1; #1;
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL post_rst_write got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        tick();
        chk_cnt++; if (dev_mem_is_write !== 1'b0) $display("FAIL post_rst_write2 got=%b exp=0", dev_mem_is_write); else pass_cnt++;
        data_opt = LW; data_addr = 32'h0002_0004; #1;
        chk_cnt++; if (exc_code !== TLBL) $display("FAIL post_rst_lookup got=%0d exp=%0d", exc_code, TLBL); else pass_cnt++;
        data_opt = OPT_NONE;
    endtask

`ifdef MMU_TLB_PROBE_EN
    task automatic test_probe();
        chk_cnt++; if (probe_hit !== 1'b0) $display("FAIL probe_rst_hit got=%b exp=0", probe_hit); else pass_cnt++;
        chk_cnt++; if (probe_index !== 4'd0) $display("FAIL probe_rst_idx got=%0d exp=0", probe_index); else pass_cnt++;
        tlb_write(4'd1, mk_entry(19'h55, 8'd9, 1'b0, 20'h0, 1'b0, 1'b0, 20'h1, 1'b1, 1'b1));
        tlb_write(4'd2, mk_entry(19'h55, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h2, 1'b1, 1'b1));
        tlb_write(4'd7, mk_entry(19'h55, 8'd3, 1'b1, 20'h0, 1'b0, 1'b0, 20'h7, 1'b1, 1'b1));
        cur_asid = 8'd5; probe_req = 1'b1; probe_vpn2 = 19'h55;
        tick();
        probe_req = 1'b0; probe_vpn2 = 19'h77;
        chk_cnt++; if (probe_hit !== 1'b1) $display("FAIL probe_hit got=%b exp=1", probe_hit); else pass_cnt++;
        chk_cnt++; if (probe_index !== 4'd2) $display("FAIL probe_idx got=%0d exp=2", probe_index); else pass_cnt++;
        tick();
        chk_cnt++; if (probe_index !== 4'd2) $display("FAIL probe_hold got=%0d exp=2", probe_index); else pass_cnt++;
        probe_req = 1'b1;
        tick();
        probe_req = 1'b0;
        chk_cnt++; if (probe_hit !== 1'b0) $display("FAIL probe_miss got=%b exp=0", probe_hit); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_tlb_load();
        test_asid_global();
        test_sub_stores();
        test_kernel_loads();
        test_store_faults();
        test_reset_mid_merge();
`ifdef MMU_TLB_PROBE_EN
        test_probe();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
